// File: rtl/reg_file_pkg.sv
// Shared types and constants for the parametrised register file.
//   scan_state_e    : scan engine states (IDLE, SCAN, DONE)
//   SCAN_MODE_DUMP  : scan streams registers out unchanged
//   SCAN_MODE_CLEAR : scan zeroes each register once its beat is accepted
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam logic SCAN_MODE_DUMP  = 1'b0;
  localparam logic SCAN_MODE_CLEAR = 1'b1;

endpackage

// File: rtl/reg_file_scan_ctrl.sv
// Scan engine: walks the register file over a valid/ready handshake.
//   clk_i, reset_i  : clock, synchronous active-high reset
//   scan_req_i      : start request, sampled only in IDLE
//   scan_clear_i    : mode captured with the request (dump / dump-and-clear)
//   scan_ready_i    : consumer accepts the current beat
//   scan_valid_o    : beat valid (SCAN state)
//   scan_addr_o     : address of the current beat, 0 outside SCAN
//   scan_busy_o     : engine not in IDLE
//   scan_done_o     : one-cycle pulse in DONE
//   clr_o           : clear strobe for the register at clr_addr_o
//   clr_addr_o      : register to clear this cycle
module reg_file_scan_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              scan_req_i,
  input  logic              scan_clear_i,
  input  logic              scan_ready_i,
  output logic              scan_valid_o,
  output logic [ADDR_W-1:0] scan_addr_o,
  output logic              scan_busy_o,
  output logic              scan_done_o,
  output logic              clr_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mode_q, mode_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mode_q  <= SCAN_MODE_DUMP;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mode_d       = mode_q;
    scan_valid_o = 1'b0;
    scan_addr_o  = '0;
    scan_busy_o  = 1'b0;
    scan_done_o  = 1'b0;
    clr_o        = 1'b0;
    clr_addr_o   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (scan_req_i) begin
          state_d = SCAN;
          ptr_d   = '0;
          mode_d  = scan_clear_i;
        end
      end
      SCAN: begin
        scan_valid_o = 1'b1;
        scan_addr_o  = ptr_q;
        scan_busy_o  = 1'b1;
        if (scan_ready_i) begin
          clr_o = (mode_q == SCAN_MODE_CLEAR);
          // DEPTH is a power of two, so the last address is all ones.
          if (ptr_q == '1) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      DONE: begin
        scan_busy_o = 1'b1;
        scan_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with two combinational read ports, one
// synchronous write port, optional write-to-read bypass, optional
// hard-wired zero register, and a scan engine for debug dump/context save.
//   CLK, RESET             : clock, synchronous active-high reset
//   WRITE/INADDRESS/IN     : write port
//   OUT1ADDRESS/OUT1       : read port 1
//   OUT2ADDRESS/OUT2       : read port 2
//   SCAN_REQ/SCAN_CLEAR    : scan start and mode
//   SCAN_READY/SCAN_VALID  : scan handshake
//   SCAN_ADDR/SCAN_DATA    : current scan beat (stored value, no bypass)
//   SCAN_BUSY/SCAN_DONE    : engine active / end-of-scan pulse
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG0 = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              SCAN_REQ,
  input  logic              SCAN_CLEAR,
  input  logic              SCAN_READY,
  output logic              SCAN_VALID,
  output logic [ADDR_W-1:0] SCAN_ADDR,
  output logic [DATA_W-1:0] SCAN_DATA,
  output logic              SCAN_BUSY,
  output logic              SCAN_DONE
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam logic        BYP_EN  = (BYPASS != 0);
  localparam logic        ZERO_EN = (ZERO_REG0 != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              clr;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;

  reg_file_scan_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_scan_ctrl (
    .clk_i        (CLK),
    .reset_i      (RESET),
    .scan_req_i   (SCAN_REQ),
    .scan_clear_i (SCAN_CLEAR),
    .scan_ready_i (SCAN_READY),
    .scan_valid_o (SCAN_VALID),
    .scan_addr_o  (SCAN_ADDR),
    .scan_busy_o  (SCAN_BUSY),
    .scan_done_o  (SCAN_DONE),
    .clr_o        (clr),
    .clr_addr_o   (clr_addr)
  );

  assign wr_en = WRITE && !(ZERO_EN && (INADDRESS == '0));

  // Clear is applied first so a same-cycle write to the scanned register wins.
  always_comb begin
    regs_d = regs_q;
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else begin
      if (clr) begin
        regs_d[clr_addr] = '0;
      end
      if (wr_en) begin
        regs_d[INADDRESS] = IN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  // Zero register overrides bypass; bypass overrides stored value.
  assign OUT1 = (ZERO_EN && (OUT1ADDRESS == '0))                ? '0 :
                (BYP_EN && WRITE && (INADDRESS == OUT1ADDRESS)) ? IN :
                                                                  regs_q[OUT1ADDRESS];
  assign OUT2 = (ZERO_EN && (OUT2ADDRESS == '0))                ? '0 :
                (BYP_EN && WRITE && (INADDRESS == OUT2ADDRESS)) ? IN :
                                                                  regs_q[OUT2ADDRESS];

  assign SCAN_DATA = !SCAN_VALID                        ? '0 :
                     (ZERO_EN && (SCAN_ADDR == '0))     ? '0 :
                                                          regs_q[SCAN_ADDR];

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (bypass / zero-register variants)
// share one stimulus stream and are compared every cycle against a
// behavioural model, with directed literal expectations on top.
module tb_reg_file_param;

  logic       CLK = 1'b0;
  logic       RESET, WRITE, SCAN_REQ, SCAN_CLEAR, SCAN_READY;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] IN;

  logic [7:0] a_out1, a_out2, a_sd, b_out1, b_out2, b_sd;
  logic [2:0] a_sa, b_sa;
  logic       a_sv, a_busy, a_done, b_sv, b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 CLK = ~CLK;

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG0(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(a_out1), .OUT2(a_out2),
    .SCAN_REQ(SCAN_REQ), .SCAN_CLEAR(SCAN_CLEAR), .SCAN_READY(SCAN_READY),
    .SCAN_VALID(a_sv), .SCAN_ADDR(a_sa), .SCAN_DATA(a_sd),
    .SCAN_BUSY(a_busy), .SCAN_DONE(a_done));

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG0(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(b_out1), .OUT2(b_out2),
    .SCAN_REQ(SCAN_REQ), .SCAN_CLEAR(SCAN_CLEAR), .SCAN_READY(SCAN_READY),
    .SCAN_VALID(b_sv), .SCAN_ADDR(b_sa), .SCAN_DATA(b_sd),
    .SCAN_BUSY(b_busy), .SCAN_DONE(b_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0][7:0] ma = '0;  // instance A contents
  logic [7:0][7:0] mb = '0;  // instance B contents (r0 never written)
  bit m_scan = 0, m_done = 0, m_clr = 0;
  int m_idx = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      ma = '0; mb = '0; m_scan = 0; m_done = 0; m_idx = 0; m_clr = 0;
    end else begin
      if (m_scan && SCAN_READY && m_clr) begin
        ma[m_idx] = 8'h00;
        mb[m_idx] = 8'h00;
      end
      if (WRITE) begin
        ma[INADDRESS] = IN;
        if (INADDRESS != 3'd0) mb[INADDRESS] = IN;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_scan) begin
        if (SCAN_READY) begin
          if (m_idx == 7) begin
            m_scan = 0;
            m_done = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (SCAN_REQ) begin
        m_scan = 1;
        m_idx  = 0;
        m_clr  = SCAN_CLEAR;
      end
    end
  end

  function automatic logic [7:0] exp_a(input logic [2:0] ad);
    return (WRITE && INADDRESS == ad) ? IN : ma[ad];
  endfunction

  function automatic logic [7:0] exp_b(input logic [2:0] ad);
    return (ad == 3'd0) ? 8'h00 : mb[ad];
  endfunction

  // Per-cycle compare, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("A.OUT1", a_out1, exp_a(OUT1ADDRESS));
      chk("A.OUT2", a_out2, exp_a(OUT2ADDRESS));
      chk("B.OUT1", b_out1, exp_b(OUT1ADDRESS));
      chk("B.OUT2", b_out2, exp_b(OUT2ADDRESS));
      chk("A.SCAN_VALID", a_sv, m_scan);
      chk("B.SCAN_VALID", b_sv, m_scan);
      chk("A.SCAN_BUSY", a_busy, m_scan || m_done);
      chk("B.SCAN_BUSY", b_busy, m_scan || m_done);
      chk("A.SCAN_DONE", a_done, m_done);
      chk("B.SCAN_DONE", b_done, m_done);
      chk("A.SCAN_ADDR", a_sa, m_scan ? m_idx : 0);
      chk("B.SCAN_ADDR", b_sa, m_scan ? m_idx : 0);
      chk("A.SCAN_DATA", a_sd, m_scan ? ma[m_idx] : 8'h00);
      chk("B.SCAN_DATA", b_sd, (m_scan && m_idx != 0) ? mb[m_idx] : 8'h00);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      WRITE = 1'b1; INADDRESS = 3'(i); IN = base + 8'(i);
      tick();
    end
    WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    bit saw_done;
    RESET = 1'b1; WRITE = 1'b0; SCAN_REQ = 1'b0; SCAN_CLEAR = 1'b0; SCAN_READY = 1'b1;
    INADDRESS = '0; IN = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    tick(); tick();
    RESET = 1'b0;
    chk_en = 1;
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd7;
    #1;
    chk("reset OUT1", a_out1, 8'h00);
    chk("reset OUT2", a_out2, 8'h00);
    chk("reset SCAN_BUSY", a_busy, 1'b0);
    chk("reset SCAN_DATA", a_sd, 8'h00);

    // Plain writes, visible next cycle.
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A; tick();
    INADDRESS = 3'd7; IN = 8'hA5; tick();
    WRITE = 1'b0; #1;
    chk("r3 read", a_out1, 8'h5A);
    chk("r7 read", a_out2, 8'hA5);
    chk("r3 read B", b_out1, 8'h5A);

    // Bypass vs no bypass.
    OUT1ADDRESS = 3'd2; WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h11; #1;
    chk("bypass OUT1", a_out1, 8'h11);
    chk("no-bypass OUT1", b_out1, 8'h00);
    tick(); WRITE = 1'b0; #1;
    chk("r2 after write B", b_out1, 8'h11);

    // Zero register.
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF; tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd0; #1;
    chk("r0 written A", a_out1, 8'hFF);
    chk("r0 zero B", b_out1, 8'h00);

    // Clear scan, READY high.
    preload(8'h10);
    SCAN_REQ = 1'b1; SCAN_CLEAR = 1'b1; tick();
    SCAN_REQ = 1'b0; done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      #1;
      if (c <= 8) begin
        chk("clr beat addr", a_sa, c - 1);
        chk("clr beat data", a_sd, 8'h10 + c - 1);
      end
      if (c == 1) chk("clr beat0 data B", b_sd, 8'h00);
      if (a_done) done_cyc = c;
      tick();
    end
    chk("clr scan done cycle", done_cyc, 9);
    chk("idle after clr scan", a_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i); #1;
      chk("cleared reg", a_out1, 8'h00);
    end

    // Dump scan with 3-cycle stall on r4 and write of r4 during the stall.
    SCAN_REQ = 1'b1; SCAN_CLEAR = 1'b0; tick();
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      SCAN_REQ   = (c == 2);
      SCAN_READY = !(c >= 5 && c <= 7);
      WRITE      = (c == 5); INADDRESS = 3'd4; IN = 8'h99;
      #1;
      if (c == 5) chk("stall beat pre-write", a_sd, 8'h00);
      if (c >= 6 && c <= 8) begin
        chk("stall beat addr", a_sa, 3'd4);
        chk("stall beat data", a_sd, 8'h99);
      end
      if (a_done) done_cyc = c;
      tick();
    end
    SCAN_REQ = 1'b0; SCAN_READY = 1'b1; WRITE = 1'b0;
    chk("stall scan done cycle", done_cyc, 12);

    // Clear scan with same-cycle write to r5: write wins.
    preload(8'h20);
    SCAN_REQ = 1'b1; SCAN_CLEAR = 1'b1; tick();
    SCAN_REQ = 1'b0; done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      WRITE = (c == 6); INADDRESS = 3'd5; IN = 8'h77;
      #1;
      if (c == 6) chk("r5 beat data", a_sd, 8'h25);
      if (a_done) done_cyc = c;
      tick();
    end
    WRITE = 1'b0;
    chk("write-wins scan done cycle", done_cyc, 9);
    OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd4; #1;
    chk("r5 write wins", a_out1, 8'h77);
    chk("r4 cleared", a_out2, 8'h00);

    // Reset in cycle 4 of a scan.
    preload(8'h30);
    SCAN_REQ = 1'b1; SCAN_CLEAR = 1'b0; tick();
    SCAN_REQ = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b1; #1;
    chk("busy before reset", a_busy, 1'b1);
    tick();
    RESET = 1'b0; #1;
    chk("busy after reset", a_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i); #1;
      chk("reg after mid-scan reset", a_out1, 8'h00);
    end
    saw_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_done) saw_done = 1;
      tick();
    end
    chk("no done after reset", saw_done, 1'b0);

    // Random traffic, checked by the per-cycle compare.
    for (int c = 0; c < 200; c++) begin
      WRITE       = 1'($urandom_range(0, 1));
      INADDRESS   = 3'($urandom_range(0, 7));
      IN          = 8'($urandom_range(0, 255));
      OUT1ADDRESS = 3'($urandom_range(0, 7));
      OUT2ADDRESS = (c % 5 == 0) ? INADDRESS : 3'($urandom_range(0, 7));
      SCAN_READY  = ($urandom_range(0, 3) != 0);
      SCAN_REQ    = ($urandom_range(0, 7) == 0);
      SCAN_CLEAR  = 1'($urandom_range(0, 1));
      tick();
    end
    WRITE = 1'b0; SCAN_REQ = 1'b0; SCAN_READY = 1'b1;
    for (int c = 0; c < 20 && a_busy; c++) tick();
    chk("idle at end", a_busy, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
